// File: rtl/hazard_scoreboard.sv
// Hazard, forwarding and flush controller for the five-stage pipeline, with a
// one-entry scoreboard tracking an in-flight multi-cycle (MDU) destination.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   id_*_i                         ID-stage sources/destination and instruction class
//   exe_*_i, mem_*_i               pending destinations in EXE and MEM
//   mdu_issue_i/rd_i/lat_i         MDU op issued from EXE this cycle
//   branch_taken_i                 taken branch at the resolve stage
//   cnt_clr_i                      synchronous clear of the performance counters
//   *_stall_o, *_flush_o           pipeline hold / bubble controls
//   fwd_rs_o, fwd_rt_o             operand source selects
//   store_fwd_o                    WB data into the MEM store-data path
//   mdu_busy_o, mdu_wb_o, mdu_wb_rd_o  scoreboard status / writeback
//   stall_cnt_o, flush_cnt_o       saturating performance counters
module hazard_scoreboard #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned MAX_LAT    = 16,
    parameter int unsigned BR_RESOLVE = 1,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned ZERO_HARD  = 1,
    localparam int unsigned LAT_W     = $clog2(MAX_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_read_rs_i,
    input  logic              id_read_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_we_i,
    input  logic              id_store_i,
    input  logic              id_mdu_i,
    input  logic [REG_AW-1:0] exe_rd_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              exe_we_i,
    input  logic              mem_we_i,
    input  logic              exe_load_i,
    input  logic              mem_load_i,
    input  logic              mdu_issue_i,
    input  logic [REG_AW-1:0] mdu_rd_i,
    input  logic [LAT_W-1:0]  mdu_lat_i,
    input  logic              branch_taken_i,
    input  logic              cnt_clr_i,
    output logic              pc_stall_o,
    output logic              if_stall_o,
    output logic              id_stall_o,
    output logic              if_flush_o,
    output logic              id_flush_o,
    output logic              exe_flush_o,
    output logic [2:0]        fwd_rs_o,
    output logic [2:0]        fwd_rt_o,
    output logic              store_fwd_o,
    output logic              mdu_busy_o,
    output logic              mdu_wb_o,
    output logic [REG_AW-1:0] mdu_wb_rd_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [LAT_W-1:0] LatOne   = LAT_W'(1);
    localparam logic [LAT_W-1:0] LatMax   = LAT_W'(MAX_LAT);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
    localparam logic             ZeroHard = (ZERO_HARD != 0);
    localparam logic             BrInMem  = (BR_RESOLVE != 0);

    localparam logic [2:0] FwdRf     = 3'b000;
    localparam logic [2:0] FwdExe    = 3'b001;
    localparam logic [2:0] FwdMemAlu = 3'b010;
    localparam logic [2:0] FwdMemLd  = 3'b011;
    localparam logic [2:0] FwdMduWb  = 3'b100;

    logic              mdu_busy_q, mdu_busy_d;
    logic [REG_AW-1:0] sb_rd_q, sb_rd_d;
    logic [LAT_W-1:0]  count_q, count_d;
    logic [LAT_W-1:0]  lat_clamped;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic zero_rs, zero_rt;
    logic exe_hit_rs, exe_hit_rt, mem_hit_rs, mem_hit_rt;
    logic sb_hit_rs, sb_hit_rt, wb_hit_rs, wb_hit_rt;
    logic mdu_wb, mdu_hold, load_use, store_byp, hazard, issue_ok;

    function automatic logic [2:0] fwd_sel(logic exe_hit, logic mem_hit, logic mem_load,
                                           logic wb_hit);
        if (exe_hit)      return FwdExe;
        else if (mem_hit) return mem_load ? FwdMemLd : FwdMemAlu;
        else if (wb_hit)  return FwdMduWb;
        else              return FwdRf;
    endfunction

    assign zero_rs = ZeroHard && (id_rs_i == '0);
    assign zero_rt = ZeroHard && (id_rt_i == '0);

    assign exe_hit_rs = id_read_rs_i && (id_rs_i == exe_rd_i) && exe_we_i && !zero_rs;
    assign exe_hit_rt = id_read_rt_i && (id_rt_i == exe_rd_i) && exe_we_i && !zero_rt;
    assign mem_hit_rs = id_read_rs_i && (id_rs_i == mem_rd_i) && mem_we_i && !zero_rs;
    assign mem_hit_rt = id_read_rt_i && (id_rt_i == mem_rd_i) && mem_we_i && !zero_rt;

    assign mdu_wb    = mdu_busy_q && (count_q == '0);
    // Busy and not finishing this cycle: the entry still blocks readers/writers.
    assign mdu_hold  = mdu_busy_q && !mdu_wb;
    assign sb_hit_rs = id_read_rs_i && mdu_busy_q && (id_rs_i == sb_rd_q) && !zero_rs;
    assign sb_hit_rt = id_read_rt_i && mdu_busy_q && (id_rt_i == sb_rd_q) && !zero_rt;
    assign wb_hit_rs = mdu_wb && sb_hit_rs;
    assign wb_hit_rt = mdu_wb && sb_hit_rt;

    // A store only needs the loaded value as data in MEM, so it bypasses instead of stalling.
    assign load_use  = exe_load_i && (exe_hit_rs || (exe_hit_rt && !id_store_i));
    assign store_byp = id_store_i && exe_load_i && exe_hit_rt;

    assign hazard = load_use
                  || (mdu_hold && (sb_hit_rs || sb_hit_rt))
                  || (mdu_hold && id_we_i && (id_rd_i == sb_rd_q))
                  || (mdu_hold && id_mdu_i);

    always_comb begin
        pc_stall_o  = 1'b0;
        if_stall_o  = 1'b0;
        id_stall_o  = 1'b0;
        if_flush_o  = 1'b0;
        id_flush_o  = 1'b0;
        exe_flush_o = 1'b0;
        fwd_rs_o    = FwdRf;
        fwd_rt_o    = FwdRf;
        store_fwd_o = 1'b0;
        if (branch_taken_i) begin
            if_flush_o  = 1'b1;
            id_flush_o  = 1'b1;
            exe_flush_o = BrInMem;
        end else if (hazard) begin
            pc_stall_o  = 1'b1;
            if_stall_o  = 1'b1;
            id_stall_o  = 1'b1;
            exe_flush_o = 1'b1;
        end else begin
            fwd_rs_o = fwd_sel(exe_hit_rs, mem_hit_rs, mem_load_i, wb_hit_rs);
            if (store_byp) begin
                store_fwd_o = 1'b1;
            end else begin
                fwd_rt_o = fwd_sel(exe_hit_rt, mem_hit_rt, mem_load_i, wb_hit_rt);
            end
        end
    end

    // A squashed EXE op or an issue while the entry is still blocking is dropped.
    assign issue_ok = mdu_issue_i && !(branch_taken_i && BrInMem) && !mdu_hold;

    always_comb begin
        lat_clamped = mdu_lat_i;
        if (mdu_lat_i == '0) begin
            lat_clamped = LatOne;
        end else if (mdu_lat_i > LatMax) begin
            lat_clamped = LatMax;
        end
        mdu_busy_d = mdu_busy_q;
        sb_rd_d    = sb_rd_q;
        count_d    = count_q;
        if (issue_ok) begin
            mdu_busy_d = 1'b1;
            sb_rd_d    = mdu_rd_i;
            count_d    = lat_clamped - LatOne;
        end else if (mdu_wb) begin
            mdu_busy_d = 1'b0;
        end else if (mdu_busy_q) begin
            count_d = count_q - LatOne;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (pc_stall_o && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CntOne;
            if (branch_taken_i && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_busy_q  <= 1'b0;
            sb_rd_q     <= '0;
            count_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            mdu_busy_q  <= mdu_busy_d;
            sb_rd_q     <= sb_rd_d;
            count_q     <= count_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mdu_busy_o  = mdu_busy_q;
    assign mdu_wb_o    = mdu_wb;
    assign mdu_wb_rd_o = sb_rd_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: reset checks, a directed vector table,
// hand-written multi-cycle sequences and randomized traffic against a reference model.
module tb_hazard_scoreboard;

    localparam int unsigned MaxLat = 6;
    localparam int unsigned CntW   = 4;
    localparam int          CntMax = (1 << CntW) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, id_rd, exe_rd, mem_rd, mdu_rd;
    logic       id_read_rs, id_read_rt, id_we, id_store, id_mdu;
    logic       exe_we, mem_we, exe_load, mem_load, mdu_issue, branch_taken, cnt_clr;
    logic [2:0] mdu_lat;
    logic       pc_stall, if_stall, id_stall, if_flush, id_flush, exe_flush;
    logic [2:0] fwd_rs, fwd_rt;
    logic       store_fwd, mdu_busy, mdu_wb;
    logic [4:0] mdu_wb_rd;
    logic [CntW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_AW    (5),
        .MAX_LAT   (MaxLat),
        .BR_RESOLVE(1),
        .CNT_W     (CntW),
        .ZERO_HARD (1)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_read_rs_i  (id_read_rs),
        .id_read_rt_i  (id_read_rt),
        .id_rd_i       (id_rd),
        .id_we_i       (id_we),
        .id_store_i    (id_store),
        .id_mdu_i      (id_mdu),
        .exe_rd_i      (exe_rd),
        .mem_rd_i      (mem_rd),
        .exe_we_i      (exe_we),
        .mem_we_i      (mem_we),
        .exe_load_i    (exe_load),
        .mem_load_i    (mem_load),
        .mdu_issue_i   (mdu_issue),
        .mdu_rd_i      (mdu_rd),
        .mdu_lat_i     (mdu_lat),
        .branch_taken_i(branch_taken),
        .cnt_clr_i     (cnt_clr),
        .pc_stall_o    (pc_stall),
        .if_stall_o    (if_stall),
        .id_stall_o    (id_stall),
        .if_flush_o    (if_flush),
        .id_flush_o    (id_flush),
        .exe_flush_o   (exe_flush),
        .fwd_rs_o      (fwd_rs),
        .fwd_rt_o      (fwd_rt),
        .store_fwd_o   (store_fwd),
        .mdu_busy_o    (mdu_busy),
        .mdu_wb_o      (mdu_wb),
        .mdu_wb_rd_o   (mdu_wb_rd),
        .stall_cnt_o   (stall_cnt),
        .flush_cnt_o   (flush_cnt)
    );

    typedef struct packed {
        logic [4:0] rs, rt;
        logic       rd_rs, rd_rt;
        logic [4:0] rd;
        logic       we, store, mdu;
        logic [4:0] exe_rd, mem_rd;
        logic       exe_we, mem_we, exe_load, mem_load;
        logic       issue;
        logic [4:0] mdu_rd;
        logic [2:0] lat;
        logic       br, clr;
    } vin_t;

    typedef struct packed {
        logic       stall;
        logic [2:0] flush, fwd_rs, fwd_rt;
        logic       sf, wb;
    } exp_t;

    typedef struct {
        vin_t       v;
        logic       stall;
        logic [2:0] flush, fwd_rs, fwd_rt;
        logic       sf;
    } tvec_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    // Reference state: the MDU entry is described by the absolute edge at which it retires.
    int    n_edge   = 0;
    bit    m_busy   = 0;
    int    m_rd     = 0;
    int    m_wb_at  = 0;
    int    m_scnt   = 0;
    int    m_fcnt   = 0;
    vin_t  cur;
    tvec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hit(logic rd, logic [4:0] x, logic [4:0] srd, logic swe);
        return rd && (x == srd) && swe && (x != 0);
    endfunction

    function automatic bit sb_hit(logic rd, logic [4:0] x);
        return rd && m_busy && (int'(x) == m_rd) && (x != 0);
    endfunction

    function automatic logic [2:0] pick(bit e, bit m, bit ml, bit w);
        if (e) return 3'd1;
        if (m) return ml ? 3'd3 : 3'd2;
        if (w) return 3'd4;
        return 3'd0;
    endfunction

    function automatic exp_t predict(vin_t v);
        exp_t e;
        bit wb, hold, ers, ert, mrs, mrt, stall;
        e    = '0;
        wb   = m_busy && (n_edge + 1 == m_wb_at);
        hold = m_busy && !wb;
        ers  = hit(v.rd_rs, v.rs, v.exe_rd, v.exe_we);
        ert  = hit(v.rd_rt, v.rt, v.exe_rd, v.exe_we);
        mrs  = hit(v.rd_rs, v.rs, v.mem_rd, v.mem_we);
        mrt  = hit(v.rd_rt, v.rt, v.mem_rd, v.mem_we);
        stall = (v.exe_load && (ers || (ert && !v.store)))
             || (hold && (sb_hit(v.rd_rs, v.rs) || sb_hit(v.rd_rt, v.rt)))
             || (hold && v.we && int'(v.rd) == m_rd)
             || (hold && v.mdu);
        e.wb = wb;
        if (v.br) begin
            e.flush = 3'b111;
        end else if (stall) begin
            e.stall = 1'b1;
            e.flush = 3'b001;
        end else begin
            e.fwd_rs = pick(ers, mrs, v.mem_load, wb && sb_hit(v.rd_rs, v.rs));
            if (v.store && v.exe_load && ert) e.sf = 1'b1;
            else e.fwd_rt = pick(ert, mrt, v.mem_load, wb && sb_hit(v.rd_rt, v.rt));
        end
        return e;
    endfunction

    task automatic drive(input vin_t v);
        id_rs = v.rs;          id_rt = v.rt;
        id_read_rs = v.rd_rs;  id_read_rt = v.rd_rt;
        id_rd = v.rd;          id_we = v.we;
        id_store = v.store;    id_mdu = v.mdu;
        exe_rd = v.exe_rd;     mem_rd = v.mem_rd;
        exe_we = v.exe_we;     mem_we = v.mem_we;
        exe_load = v.exe_load; mem_load = v.mem_load;
        mdu_issue = v.issue;   mdu_rd = v.mdu_rd;
        mdu_lat = v.lat;       branch_taken = v.br;
        cnt_clr = v.clr;
    endtask

    // Drive one cycle's inputs and compare every output against the model at the negedge.
    task automatic apply(input vin_t v);
        exp_t e;
        cur = v;
        drive(v);
        @(negedge clk);
        e = predict(cur);
        check("stall", {pc_stall, if_stall, id_stall}, e.stall ? 3'b111 : 3'b000);
        check("flush", {if_flush, id_flush, exe_flush}, e.flush);
        check("fwd_rs", fwd_rs, e.fwd_rs);
        check("fwd_rt", fwd_rt, e.fwd_rt);
        check("store_fwd", store_fwd, e.sf);
        check("mdu_busy", mdu_busy, m_busy);
        check("mdu_wb", mdu_wb, e.wb);
        if (e.wb) check("mdu_wb_rd", mdu_wb_rd, m_rd);
        check("stall_cnt", stall_cnt, m_scnt);
        check("flush_cnt", flush_cnt, m_fcnt);
    endtask

    task automatic advance();
        exp_t e;
        bit   acc;
        int   eff;
        e   = predict(cur);
        acc = cur.issue && !cur.br && !(m_busy && !e.wb);
        eff = (cur.lat == 0) ? 1 : ((int'(cur.lat) > MaxLat) ? MaxLat : int'(cur.lat));
        @(posedge clk);
        if (acc) begin
            m_busy  = 1;
            m_rd    = cur.mdu_rd;
            m_wb_at = n_edge + 1 + eff;
        end else if (e.wb) begin
            m_busy = 0;
        end
        if (cur.clr) m_scnt = 0;
        else if (e.stall && m_scnt < CntMax) m_scnt++;
        if (cur.clr) m_fcnt = 0;
        else if (cur.br && m_fcnt < CntMax) m_fcnt++;
        n_edge++;
        #1;
    endtask

    task automatic add(input vin_t v, input logic st, input logic [2:0] fl,
                       input logic [2:0] fr, input logic [2:0] ft, input logic sf);
        tvec_t t;
        t.v = v; t.stall = st; t.flush = fl; t.fwd_rs = fr; t.fwd_rt = ft; t.sf = sf;
        tbl.push_back(t);
    endtask

    initial begin
        vin_t v;
        v = '0;
        cur = '0;
        drive(v);
        rst_n = 1'b0;
        #3;
        check("rst_stall", {pc_stall, if_stall, id_stall}, 3'b000);
        check("rst_flush", {if_flush, id_flush, exe_flush}, 3'b000);
        check("rst_fwd", {fwd_rs, fwd_rt}, 6'd0);
        check("rst_store_fwd", store_fwd, 1'b0);
        check("rst_busy", mdu_busy, 1'b0);
        check("rst_wb", mdu_wb, 1'b0);
        check("rst_cnts", {stall_cnt, flush_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        n_edge++;
        #1;

        // Directed table, scoreboard idle.
        v = '0; add(v, 0, 3'b000, 3'd0, 3'd0, 0);
        v = '0; v.rd_rs = 1; v.rs = 5; v.exe_rd = 5; v.exe_we = 1; v.exe_load = 1;
        add(v, 1, 3'b001, 3'd0, 3'd0, 0);
        v = '0; v.store = 1; v.rd_rt = 1; v.rt = 5; v.rd_rs = 1; v.rs = 3;
        v.exe_rd = 5; v.exe_we = 1; v.exe_load = 1;
        add(v, 0, 3'b000, 3'd0, 3'd0, 1);
        v = '0; v.rd_rs = 1; v.rs = 5; v.exe_rd = 5; v.exe_we = 1;
        add(v, 0, 3'b000, 3'd1, 3'd0, 0);
        v = '0; v.rd_rt = 1; v.rt = 6; v.mem_rd = 6; v.mem_we = 1; v.mem_load = 1;
        add(v, 0, 3'b000, 3'd0, 3'd3, 0);
        v = '0; v.rd_rs = 1; v.rs = 9; v.rd_rt = 1; v.rt = 9; v.mem_rd = 9; v.mem_we = 1;
        add(v, 0, 3'b000, 3'd2, 3'd2, 0);
        v = '0; v.rd_rs = 1; v.rs = 4; v.exe_rd = 4; v.exe_we = 1; v.mem_rd = 4;
        v.mem_we = 1; v.mem_load = 1;
        add(v, 0, 3'b000, 3'd1, 3'd0, 0);
        v = '0; v.rs = 5; v.exe_rd = 5; v.exe_we = 1; v.exe_load = 1;
        add(v, 0, 3'b000, 3'd0, 3'd0, 0);
        v = '0; v.rd_rs = 1; v.rd_rt = 1; v.exe_we = 1; v.exe_load = 1; v.mem_we = 1;
        add(v, 0, 3'b000, 3'd0, 3'd0, 0);
        v = '0; v.rd_rs = 1; v.rs = 5; v.exe_rd = 5; v.exe_load = 1;
        add(v, 0, 3'b000, 3'd0, 3'd0, 0);
        v = '0; v.br = 1; v.rd_rs = 1; v.rs = 5; v.exe_rd = 5; v.exe_we = 1; v.exe_load = 1;
        add(v, 0, 3'b111, 3'd0, 3'd0, 0);
        v = '0; v.br = 1; v.rd_rs = 1; v.rs = 5; v.exe_rd = 5; v.exe_we = 1;
        add(v, 0, 3'b111, 3'd0, 3'd0, 0);
        v = '0; v.rd_rt = 1; v.rt = 8; v.exe_rd = 8; v.exe_we = 1; v.exe_load = 1;
        add(v, 1, 3'b001, 3'd0, 3'd0, 0);
        v = '0; v.store = 1; v.rd_rs = 1; v.rs = 5; v.exe_rd = 5; v.exe_we = 1;
        v.exe_load = 1;
        add(v, 1, 3'b001, 3'd0, 3'd0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].v);
            check($sformatf("tbl%0d_stall", i), {pc_stall, if_stall, id_stall},
                  tbl[i].stall ? 3'b111 : 3'b000);
            check($sformatf("tbl%0d_flush", i), {if_flush, id_flush, exe_flush}, tbl[i].flush);
            check($sformatf("tbl%0d_fwd_rs", i), fwd_rs, tbl[i].fwd_rs);
            check($sformatf("tbl%0d_fwd_rt", i), fwd_rt, tbl[i].fwd_rt);
            check($sformatf("tbl%0d_store_fwd", i), store_fwd, tbl[i].sf);
            advance();
        end

        // Load-use: one stall cycle, then MEM load forwarding.
        v = '0; v.rd_rs = 1; v.rs = 5; v.exe_rd = 5; v.exe_we = 1; v.exe_load = 1;
        apply(v);
        check("lu_stall", pc_stall, 1'b1);
        check("lu_bubble", exe_flush, 1'b1);
        advance();
        v = '0; v.rd_rs = 1; v.rs = 5; v.mem_rd = 5; v.mem_we = 1; v.mem_load = 1;
        apply(v);
        check("lu_after_stall", pc_stall, 1'b0);
        check("lu_fwd_mem_load", fwd_rs, 3'd3);
        advance();

        // MDU rd=7, latency 4: RAW stall for three cycles, writeback forward in the fourth.
        v = '0; v.issue = 1; v.mdu_rd = 7; v.lat = 4;
        apply(v);
        advance();
        for (int k = 1; k <= 4; k++) begin
            v = '0; v.rd_rs = 1; v.rs = 7;
            apply(v);
            if (k < 4) begin
                check($sformatf("mdu_raw_stall_c%0d", k), pc_stall, 1'b1);
                check($sformatf("mdu_no_wb_c%0d", k), mdu_wb, 1'b0);
            end else begin
                check("mdu_wb_c4", mdu_wb, 1'b1);
                check("mdu_wb_rd_c4", mdu_wb_rd, 5'd7);
                check("mdu_fwd_c4", fwd_rs, 3'd4);
                check("mdu_no_stall_c4", pc_stall, 1'b0);
            end
            advance();
        end
        check("mdu_busy_after_wb", mdu_busy, 1'b0);

        // Branch overrides load-use and squashes a concurrent MDU issue.
        v = '0; v.br = 1; v.rd_rs = 1; v.rs = 5; v.exe_rd = 5; v.exe_we = 1; v.exe_load = 1;
        v.issue = 1; v.mdu_rd = 9; v.lat = 2;
        apply(v);
        check("br_flush", {if_flush, id_flush, exe_flush}, 3'b111);
        check("br_no_stall", pc_stall, 1'b0);
        advance();
        check("br_issue_dropped", mdu_busy, 1'b0);

        // Asynchronous reset in the middle of an MDU op.
        v = '0; v.issue = 1; v.mdu_rd = 12; v.lat = 6;
        apply(v);
        advance();
        v = '0;
        apply(v);
        check("mid_busy", mdu_busy, 1'b1);
        advance();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", mdu_busy, 1'b0);
        check("arst_wb", mdu_wb, 1'b0);
        check("arst_stall_cnt", stall_cnt, 0);
        check("arst_flush_cnt", flush_cnt, 0);
        m_busy = 0; m_scnt = 0; m_fcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        n_edge++;
        #1;
        for (int k = 0; k < 8; k++) begin
            v = '0;
            apply(v);
            advance();
        end

        // Saturate the 4-bit stall counter, then clear while still stalling.
        v = '0; v.rd_rs = 1; v.rs = 5; v.exe_rd = 5; v.exe_we = 1; v.exe_load = 1;
        for (int k = 0; k < CntMax + 4; k++) begin
            apply(v);
            advance();
        end
        check("stall_cnt_sat", stall_cnt, CntMax);
        v.clr = 1;
        apply(v);
        advance();
        check("stall_cnt_clr", stall_cnt, 0);

        // Randomized traffic over a small register set to provoke frequent matches.
        for (int i = 0; i < 3000; i++) begin
            v.rs       = 5'($urandom_range(0, 3));
            v.rt       = 5'($urandom_range(0, 3));
            v.rd       = 5'($urandom_range(0, 3));
            v.exe_rd   = 5'($urandom_range(0, 3));
            v.mem_rd   = 5'($urandom_range(0, 3));
            v.mdu_rd   = 5'($urandom_range(0, 3));
            v.rd_rs    = 1'($urandom_range(0, 1));
            v.rd_rt    = 1'($urandom_range(0, 1));
            v.we       = 1'($urandom_range(0, 1));
            v.store    = 1'($urandom_range(0, 1));
            v.mdu      = ($urandom_range(0, 3) == 0);
            v.exe_we   = 1'($urandom_range(0, 1));
            v.mem_we   = 1'($urandom_range(0, 1));
            v.exe_load = 1'($urandom_range(0, 1));
            v.mem_load = 1'($urandom_range(0, 1));
            v.issue    = ($urandom_range(0, 2) == 0);
            v.lat      = 3'($urandom_range(0, 7));
            v.br       = ($urandom_range(0, 15) == 0);
            v.clr      = ($urandom_range(0, 15) == 0);
            apply(v);
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard, forwarding and flush controller for the five-stage pipeline, extended with a one-entry scoreboard for a multi-cycle unit (MDU: mul/div). Sits beside the ID stage. Every cycle it decides:
- PC/IF/ID stalls;
- IF/ID/EXE flushes;
- per-operand forwarding selects and load-to-store data bypass.

It also tracks the in-flight MDU destination with a latency countdown and keeps saturating stall/flush performance counters.

## Interface
Parameters:
- REG_AW, 5: register index width (2^REG_AW architectural registers).
- MAX_LAT, 16: maximum MDU latency in cycles; LAT_W = $clog2(MAX_LAT+1).
- BR_RESOLVE, 1: 0 = branch resolved in EXE (flush IF, ID); 1 = resolved in MEM (flush IF, ID, EXE).
- CNT_W, 32: performance counter width.
- ZERO_HARD, 1: 1 = register 0 never creates a hazard and is never forwarded.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  REG_AW  ID source registers.
- id_read_rs, id_read_rt  in  1  source actually read.
- id_rd  in  REG_AW  ID destination; id_we  in  1  ID writes id_rd.
- id_store  in  1  ID is a store (rt = store data).
- id_mdu  in  1  ID is an MDU instruction.
- exe_rd, mem_rd  in  REG_AW  destinations in EXE, MEM.
- exe_we, mem_we  in  1  register write pending.
- exe_load, mem_load  in  1  load in EXE, MEM.
- mdu_issue  in  1  EXE issues its MDU op this cycle.
- mdu_rd  in  REG_AW  MDU destination.
- mdu_lat  in  LAT_W  MDU latency.
- branch_taken  in  1  taken branch/jump at the BR_RESOLVE stage.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_stall, if_stall, id_stall  out  1  hold register.
- if_flush, id_flush, exe_flush  out  1  insert bubble.
- fwd_rs, fwd_rt  out  3  operand source: 000 regfile, 001 EXE result, 010 MEM ALU result, 011 MEM load data, 100 MDU writeback.
- store_fwd  out  1  forward WB data into the MEM store-data path.
- mdu_busy  out  1  MDU op in flight.
- mdu_wb  out  1  MDU result written this cycle; mdu_wb_rd  out  REG_AW.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

## Operation
- Hazard matching:
  - src X matches stage S when read_X && X==S_rd && S_we && !(ZERO_HARD && X==0).
  - MDU match (mduhit): mdu_busy && X==sb_rd && !(ZERO_HARD && X==0).
- Priority 1, branch_taken:
  - if_flush=id_flush=1; exe_flush=BR_RESOLVE.
  - All stalls 0; fwd 000; store_fwd 0.
  - Overrides every hazard.
- Priority 2, stall (pc_stall=if_stall=id_stall=1, exe_flush=1 as bubble, fwd 000) on any of:
  - (a) load-use: EXE load match on rs; or EXE load match on rt when !id_store.
  - (b) RAW on MDU: mduhit on a read source, unless mdu_wb this cycle.
  - (c) WAW: id_we && id_rd==sb_rd && mdu_busy && !mdu_wb.
  - (d) structural: id_mdu && mdu_busy && !mdu_wb.
- Priority 3, forwarding, per source, first match wins:
  - EXE match → 001.
  - MEM match → 011 if mem_load, else 010.
  - mdu_wb && X==mdu_wb_rd → 100.
  - Otherwise 000.
- Store special case: id_store with EXE load match on rt only → no stall; store_fwd=1; fwd_rt=000. fwd_rs is still computed normally.
- Scoreboard, one entry: sb_rd, count.
  - On accepted mdu_issue: mdu_busy←1, sb_rd←mdu_rd.
  - count←clamp(mdu_lat,1,MAX_LAT)−1.
  - Each later cycle count decrements. mdu_wb=1 (combinational) when mdu_busy && count==0; mdu_wb_rd=sb_rd.
  - At that edge mdu_busy←0, unless a new issue is accepted in the same cycle; the new issue wins.
  - Issue rejected (ignored) when branch_taken && BR_RESOLVE==1, because the EXE instruction is squashed.
  - Issue is also ignored while mdu_busy && !mdu_wb (protocol error; no state change).
- Counters:
  - stall_cnt +1 per cycle with pc_stall.
  - flush_cnt +1 per cycle with branch_taken.
  - Both saturate at all-ones. cnt_clr has priority over increment.

## Timing
- All stall/flush/fwd/store_fwd/mdu_wb outputs are combinational from inputs plus registered state; zero-cycle latency.
- State (mdu_busy, sb_rd, count, counters) updates on the rising clk edge.
- Reset (rst_n low, asynchronous):
  - mdu_busy=0, sb_rd=0, count=0, stall_cnt=0, flush_cnt=0.
  - Hence all stalls, flushes, fwd, store_fwd and mdu_wb read 0 / 000 with branch_taken low.
- Reset mid-MDU op drops the entry; no mdu_wb follows.
- Issue at edge t with latency L: mdu_busy high from t; mdu_wb high in the cycle ending at edge t+L.
  - L=0 behaves as L=1; L>MAX_LAT behaves as MAX_LAT.
- A load-use stall lasts exactly one cycle, then the load is in MEM and forwarding 011 applies.

## Test plan
- exe_load=1, exe_rd=5, exe_we=1; ID reads rs=5 → pc/if/id_stall=1, exe_flush=1; next cycle (load in MEM) → no stall, fwd_rs=011.
- id_store=1, rt=5, rs=3; EXE load to 5 → no stall, store_fwd=1, fwd_rt=000, fwd_rs=000.
- mdu_issue rd=7, lat=4 at edge 0; ID reads 7 → stall for cycles 1–3; cycle 4 mdu_wb=1, fwd=100, no stall; mdu_busy=0 after edge 4.
- BR_RESOLVE=1: branch_taken with a concurrent load-use hazard and mdu_issue → if/id/exe_flush=1, no stall, issue ignored (mdu_busy stays 0), flush_cnt +1.
- rd=0 in EXE/MEM with ZERO_HARD=1, ID reads 0 → fwd 000, no stall; rst_n low mid-MDU op → mdu_busy=0 immediately, counters 0.
- Hold pc_stall for 2^CNT_W+3 cycles (CNT_W=4 instance) → stall_cnt sticks at 15; cnt_clr → 0 on the next edge.
